// File: rtl/serial_adder_pkg.sv
// Shared constants for the bit-serial adder: FSM encodings and default width.
// Encoding 2'd3 is never entered and falls back to IDLE in the controller.
package serial_adder_pkg;

   localparam int DEFAULT_WIDTH = 8;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   typedef enum logic [1:0] {
      IDLE = ST_IDLE,
      RUN  = ST_RUN,
      DONE = ST_DONE
   } state_t;

endpackage

// File: rtl/serial_adder_fa.sv
// One-bit full adder cell, shared by every bit position of the serial adder.
module serial_adder_fa (
   input  logic a,
   input  logic b,
   input  logic c,
   output logic sum,
   output logic carry
);

   assign sum   = a ^ b ^ c;
   assign carry = (a & b) | (c & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full-adder cell plus a carry flop, LSB first.
// Reports carry-out and two's-complement overflow once per operation.
module serial_adder
   import serial_adder_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             carry,
   output logic             overflow
);

   // Handshake: start is taken only while idle (busy=0, done=0); operands are
   // captured on that edge, busy stays high for WIDTH cycles, then done pulses
   // for exactly one cycle with the result; start outside IDLE is dropped.

   localparam int             CW   = $clog2(WIDTH) + 1;
   localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

   state_t           state, state_nxt;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] a_sr, b_sr, part_sr;
   logic             c_ff;
   logic             fa_sum, fa_carry;
   logic             last_bit;

   assign last_bit = (cnt == LAST);

   serial_adder_fa u_fa (
      .a     (a_sr[0]),
      .b     (b_sr[0]),
      .c     (c_ff),
      .sum   (fa_sum),
      .carry (fa_carry)
   );

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      busy      = 1'b0;
      done      = 1'b0;
      case (state)
         IDLE: if (start) state_nxt = RUN;
         RUN: begin
            busy = 1'b1;
            if (last_bit) state_nxt = DONE;
         end
         DONE: begin
            done      = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt      <= '0;
         c_ff     <= 1'b0;
         a_sr     <= '0;
         b_sr     <= '0;
         part_sr  <= '0;
         sum      <= '0;
         carry    <= 1'b0;
         overflow <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  a_sr <= a;
                  b_sr <= b;
                  c_ff <= cin;
                  cnt  <= '0;
               end
            end
            RUN: begin
               a_sr    <= {1'b0, a_sr[WIDTH-1:1]};
               b_sr    <= {1'b0, b_sr[WIDTH-1:1]};
               part_sr <= {fa_sum, part_sr[WIDTH-1:1]};
               c_ff    <= fa_carry;
               cnt     <= cnt + CW'(1);
               // Visible result is only written once all bits are in.
               if (last_bit) begin
                  sum      <= {fa_sum, part_sr[WIDTH-1:1]};
                  carry    <= fa_carry;
                  overflow <= c_ff ^ fa_carry;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
